fetch_queue_stage: RTL and testbench

Parametrised instruction-fetch stage that replaces the single-register IF/ID boundary with a DEPTH-entry fetch queue and a valid/ready instruction-memory interface. It generates sequential PCs, issues pipelined requests to instruction memory, reorders nothing (memory responds in order), and presents instructions to Decode with a valid/ready handshake. Redirects from Execute flush the queue and discard in-flight responses.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_slot_fifo.sv | 77 +++++++
 rtl/fetch_queue_stage.sv | 117 +++++++++++
 tb/tb_fetch_queue_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, slot type and pointer-width helpers for the fetch queue stage.
// Slot fields are sized for address/instruction widths up to 32 bits.
package fetch_pkg;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   localparam int FETCH_ADDR_W = 32;
   localparam int FETCH_INSN_W = 32;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_INSN_W-1:0] insn;
      logic                    filled;
   } fetch_slot_t;

   function automatic int fetch_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int fetch_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_slot_fifo.sv
// DEPTH-slot fetch queue: slots are reserved at the tail when a request is accepted,
// filled in order by responses, and dequeued at the head once filled.
module fetch_slot_fifo
   import fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int INSN_WIDTH = 32,
   parameter int DEPTH      = 4,
   localparam int PTR_W     = fetch_ptr_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  reserve,
   input  logic [ADDR_WIDTH-1:0] reserve_pc,
   input  logic                  fill,
   input  logic [INSN_WIDTH-1:0] fill_data,
   input  logic                  dequeue,
   output logic                  head_valid,
   output logic [ADDR_WIDTH-1:0] head_pc,
   output logic [INSN_WIDTH-1:0] head_insn,
   output logic [PTR_W:0]        count,
   output logic [PTR_W:0]        pending
);

   localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

   fetch_slot_t      slots [DEPTH];
   logic [PTR_W:0]   head_ptr;
   logic [PTR_W:0]   fill_ptr;
   logic [PTR_W:0]   tail_ptr;
   logic [PTR_W-1:0] head_idx;
   logic [PTR_W-1:0] fill_idx;
   logic [PTR_W-1:0] tail_idx;
   logic             can_fill;

   assign head_idx = head_ptr[PTR_W-1:0];
   assign fill_idx = fill_ptr[PTR_W-1:0];
   assign tail_idx = tail_ptr[PTR_W-1:0];

   // Extra wrap bit on each pointer distinguishes full from empty.
   assign count    = tail_ptr - head_ptr;
   assign pending  = tail_ptr - fill_ptr;
   assign can_fill = fill && (fill_ptr != tail_ptr);

   assign head_valid = (count != '0) && slots[head_idx].filled;
   assign head_pc    = ADDR_WIDTH'(slots[head_idx].pc);
   assign head_insn  = INSN_WIDTH'(slots[head_idx].insn);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_ptr <= '0;
         fill_ptr <= '0;
         tail_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
      end else if (flush) begin
         head_ptr <= '0;
         fill_ptr <= '0;
         tail_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
      end else begin
         if (reserve) begin
            slots[tail_idx].pc     <= FETCH_ADDR_W'(reserve_pc);
            slots[tail_idx].filled <= 1'b0;
            tail_ptr               <= tail_ptr + PTR_ONE;
         end
         // A response is never for the slot reserved on the same edge.
         if (can_fill) begin
            slots[fill_idx].insn   <= FETCH_INSN_W'(fill_data);
            slots[fill_idx].filled <= 1'b1;
            fill_ptr               <= fill_ptr + PTR_ONE;
         end
         if (dequeue && head_valid) head_ptr <= head_ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: sequential PC generation, credit-limited pipelined memory
// requests, in-order fetch queue to Decode, redirect flush. Option: FETCH_PERF_EN.
module fetch_queue_stage
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INSN_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  imem_req_valid_o,
   input  logic                  imem_req_ready_i,
   output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
   input  logic                  imem_rsp_valid_i,
   input  logic [INSN_WIDTH-1:0] imem_rsp_data_i,
   output logic                  valid_d_o,
   input  logic                  ready_d_i,
   output logic [INSN_WIDTH-1:0] ins_d_o,
   output logic [ADDR_WIDTH-1:0] pc_d_o,
   output logic [ADDR_WIDTH-1:0] pc_4d_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]           perf_fetched_o,
   output logic [31:0]           perf_flush_o,
   output logic [31:0]           perf_dropped_o
`endif
);

   localparam int             PTR_W    = fetch_ptr_w(DEPTH);
   localparam int             DROP_W   = 16;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [DROP_W-1:0]     drop_cnt;
   logic [DROP_W-1:0]     drop_next;
   logic [PTR_W:0]        count;
   logic [PTR_W:0]        pending;
   logic                  head_valid;
   logic [ADDR_WIDTH-1:0] head_pc;
   logic [INSN_WIDTH-1:0] head_insn;
   logic                  has_credit;
   logic                  accept;
   logic                  rsp_take;
   logic                  rsp_drop;
   logic                  deq;

   // Reserved-but-unfilled slots are the outstanding requests, so slot occupancy is the credit use.
   assign has_credit       = count < FULL_CNT;
   assign imem_req_valid_o = !rst && has_credit && !redirect_i;
   assign imem_req_addr_o  = pc_q;
   assign accept           = imem_req_valid_o && imem_req_ready_i;

   // A response on a redirect cycle belongs to a request being flushed, so it is discarded too.
   assign rsp_drop = imem_rsp_valid_i && ((drop_cnt != '0) || (redirect_i && (pending != '0)));
   assign rsp_take = imem_rsp_valid_i && !redirect_i && (drop_cnt == '0) && (pending != '0);
   assign deq      = head_valid && ready_d_i && !redirect_i;

   always_comb begin
      drop_next = drop_cnt - DROP_W'(rsp_drop);
      if (redirect_i) drop_next = drop_next + DROP_W'(pending);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         drop_cnt <= '0;
      end else begin
         if (redirect_i)  pc_q <= redirect_pc_i;
         else if (accept) pc_q <= pc_q + ADDR_WIDTH'(4);
         drop_cnt <= drop_next;
      end
   end

   fetch_slot_fifo #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INSN_WIDTH (INSN_WIDTH),
      .DEPTH      (DEPTH)
   ) u_slots (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_i),
      .reserve    (accept),
      .reserve_pc (pc_q),
      .fill       (rsp_take),
      .fill_data  (imem_rsp_data_i),
      .dequeue    (deq),
      .head_valid (head_valid),
      .head_pc    (head_pc),
      .head_insn  (head_insn),
      .count      (count),
      .pending    (pending)
   );

   assign valid_d_o = head_valid;
   assign ins_d_o   = head_valid ? head_insn : INSN_WIDTH'(NOP_INSN);
   assign pc_d_o    = head_valid ? head_pc : '0;
   assign pc_4d_o   = head_valid ? head_pc + ADDR_WIDTH'(4) : '0;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched_o <= '0;
         perf_flush_o   <= '0;
         perf_dropped_o <= '0;
      end else begin
         if (deq && (perf_fetched_o != '1))        perf_fetched_o <= perf_fetched_o + 32'd1;
         if (redirect_i && (perf_flush_o != '1))   perf_flush_o   <= perf_flush_o + 32'd1;
         if (rsp_drop && (perf_dropped_o != '1))   perf_dropped_o <= perf_dropped_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: in-order memory model with configurable latency,
// expected Decode PCs queued by the stimulus and checked by a separate monitor.
`timescale 1ns/1ps
module tb_fetch_queue_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i = 1'b1;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_valid_i = 1'b0;
   logic [31:0] imem_rsp_data_i = '0;
   logic        valid_d_o;
   logic        ready_d_i = 1'b0;
   logic [31:0] ins_d_o;
   logic [31:0] pc_d_o;
   logic [31:0] pc_4d_o;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_o;
   logic [31:0] perf_flush_o;
   logic [31:0] perf_dropped_o;
`endif

   always #5 clk = ~clk;

   fetch_queue_stage #(
      .ADDR_WIDTH (32),
      .INSN_WIDTH (32),
      .DEPTH      (4),
      .RESET_PC   (32'h0)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .valid_d_o        (valid_d_o),
      .ready_d_i        (ready_d_i),
      .ins_d_o          (ins_d_o),
      .pc_d_o           (pc_d_o),
      .pc_4d_o          (pc_4d_o)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched_o   (perf_fetched_o),
      .perf_flush_o     (perf_flush_o),
      .perf_dropped_o   (perf_dropped_o)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          lat = 1;
   int          cyc = 0;
   int          consumed = 0;
   int          n_acc = 0;
   logic [31:0] exp_q[$];
   logic [31:0] acc_log[$];
   mreq_t       mem_q[$];

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory request side: record accepted requests with their response cycle.
   initial begin : mem_accept
      mreq_t m;
      forever begin
         @(negedge clk);
         if (rst) begin
            mem_q.delete();
         end else if (imem_req_valid_o && imem_req_ready_i) begin
            m.addr = imem_req_addr_o;
            m.due  = cyc + lat;
            mem_q.push_back(m);
            acc_log.push_back(imem_req_addr_o);
            n_acc++;
         end
      end
   end

   // Memory response side: in order, one per cycle, once the latency has elapsed.
   initial begin : mem_rsp
      forever begin
         @(posedge clk);
         #2;
         if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_data(mem_q[0].addr);
            void'(mem_q.pop_front());
         end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
         end
      end
   end

   initial begin : monitor
      logic [31:0] e;
      logic [31:0] e4;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (valid_d_o && ready_d_i && !redirect_i) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_deq: got pc %h, required no entry", pc_d_o);
               end else begin
                  e  = exp_q.pop_front();
                  e4 = e + 32'd4;
                  chk("deq_pc", pc_d_o, e);
                  chk("deq_pc4", pc_4d_o, e4);
                  chk("deq_ins", ins_d_o, mem_data(e));
                  consumed++;
               end
            end else if (!valid_d_o) begin
               chk("idle_ins_nop", ins_d_o, 32'h0000_0013);
               chk("idle_pc_zero", pc_d_o, 32'h0);
               chk("idle_pc4_zero", pc_4d_o, 32'h0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst              = 1'b1;
      redirect_i       = 1'b0;
      ready_d_i        = 1'b0;
      imem_req_ready_i = 1'b1;
      exp_q.delete();
      acc_log.delete();
      consumed = 0;
      n_acc    = 0;
      @(negedge clk);
      chk("rst_req_valid", imem_req_valid_o, 1'b0);
      chk("rst_valid_d", valid_d_o, 1'b0);
      chk("rst_ins_nop", ins_d_o, 32'h0000_0013);
      chk("rst_pc_zero", pc_d_o, 32'h0);
      chk("rst_pc4_zero", pc_4d_o, 32'h0);
`ifdef FETCH_PERF_EN
      chk("rst_perf_fetched", perf_fetched_o, 32'd0);
      chk("rst_perf_flush", perf_flush_o, 32'd0);
      chk("rst_perf_dropped", perf_dropped_o, 32'd0);
`endif
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_consumed(input int n, input int budget, input string name);
      int k = 0;
      while (consumed < n && k < budget) begin
         tick();
         k++;
      end
      chk(name, consumed, n);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int k;

      // Back-to-back fetch from reset with a 1-cycle memory.
      do_reset();
      lat       = 1;
      ready_d_i = 1'b1;
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
      @(negedge clk);
      chk("s1_c0_req_valid", imem_req_valid_o, 1'b1);
      chk("s1_c0_addr", imem_req_addr_o, 32'h0);
      chk("s1_c0_valid_d", valid_d_o, 1'b0);
      tick();
      @(negedge clk);
      chk("s1_c1_addr", imem_req_addr_o, 32'h4);
      chk("s1_c1_valid_d", valid_d_o, 1'b0);
      tick();
      @(negedge clk);
      chk("s1_c2_addr", imem_req_addr_o, 32'h8);
      chk("s1_c2_valid_d", valid_d_o, 1'b1);
      tick();
      @(negedge clk);
      chk("s1_c3_addr", imem_req_addr_o, 32'hC);
      wait_consumed(8, 40, "s1_consumed");
      ready_d_i = 1'b0;

      // Decode stalled: exactly DEPTH requests, then resume at pc 16.
      do_reset();
      lat = 1;
      repeat (12) tick();
      @(negedge clk);
      chk("s2_issued", n_acc, 4);
      chk("s2_full_req_valid", imem_req_valid_o, 1'b0);
      chk("s2_head_valid", valid_d_o, 1'b1);
      chk("s2_head_pc", pc_d_o, 32'h0);
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
      tick();
      ready_d_i = 1'b1;
      wait_consumed(8, 40, "s2_consumed");
      ready_d_i = 1'b0;
      if (acc_log.size() > 4) chk("s2_resume_addr", acc_log[4], 32'h10);
      else chk("s2_resume_count", acc_log.size(), 5);

      // Two redirects with responses still in flight (3-cycle memory).
      do_reset();
      lat = 3;
      tick();
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h100;
      @(negedge clk);
      chk("s3_redir_no_req", imem_req_valid_o, 1'b0);
      tick();
      redirect_i = 1'b0;
      @(negedge clk);
      chk("s3_flushed_valid_d", valid_d_o, 1'b0);
      chk("s3_target_req_valid", imem_req_valid_o, 1'b1);
      chk("s3_target_addr", imem_req_addr_o, 32'h100);
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h300;
      tick();
      redirect_i = 1'b0;
      ready_d_i  = 1'b1;
      for (int i = 0; i < 10; i++) exp_q.push_back(32'h300 + 32'(4 * i));
      @(negedge clk);
      chk("s3_second_target_addr", imem_req_addr_o, 32'h300);
      chk("s3_second_valid_d", valid_d_o, 1'b0);
      wait_consumed(10, 80, "s3_consumed");
      ready_d_i = 1'b0;
`ifdef FETCH_PERF_EN
      @(negedge clk);
      chk("perf_fetched", perf_fetched_o, 32'd10);
      chk("perf_flush", perf_flush_o, 32'd2);
      chk("perf_dropped", perf_dropped_o, 32'd3);
`endif

      // Redirect on the same cycle as a response and a Decode handshake.
      do_reset();
      lat       = 1;
      ready_d_i = 1'b1;
      tick();
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h200;
      @(negedge clk);
      chk("s4_head_valid", valid_d_o, 1'b1);
      chk("s4_head_pc", pc_d_o, 32'h0);
      tick();
      redirect_i = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(4 * i));
      @(negedge clk);
      chk("s4_empty_after", valid_d_o, 1'b0);
      chk("s4_req_valid", imem_req_valid_o, 1'b1);
      chk("s4_req_addr", imem_req_addr_o, 32'h200);
      wait_consumed(4, 30, "s4_consumed");
      ready_d_i = 1'b0;

      // Toggling memory ready, 3-cycle latency, PC wrap through zero.
      do_reset();
      lat           = 3;
      ready_d_i     = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFF0;
      @(negedge clk);
      chk("s5_redir_no_req", imem_req_valid_o, 1'b0);
      tick();
      redirect_i = 1'b0;
      exp_q.push_back(32'hFFFF_FFF0);
      exp_q.push_back(32'hFFFF_FFF4);
      exp_q.push_back(32'hFFFF_FFF8);
      exp_q.push_back(32'hFFFF_FFFC);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
      k = 0;
      while (consumed < 8 && k < 100) begin
         imem_req_ready_i = (k % 2 == 0);
         tick();
         k++;
      end
      chk("s5_consumed", consumed, 8);
      ready_d_i        = 1'b0;
      imem_req_ready_i = 1'b1;

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
